// File: rtl/rob_commit_seq.sv
// Reorder buffer that allocates entries at issue, records writebacks, and retires them in order.
// A mispredicted entry at the head retires and flushes the whole buffer in the same edge.
module rob_commit_seq #(
   parameter int ROB_SIZE  = 16,
   parameter int ROB_POS_W = 4,
   parameter int REG_W     = 5,
   parameter int DATA_W    = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rdy,
   input  logic                 issue,
   input  logic [REG_W-1:0]     issue_rd,
   output logic [ROB_POS_W-1:0] issue_rob_pos,
   output logic                 full,
   input  logic                 wb_valid,
   input  logic [ROB_POS_W-1:0] wb_rob_pos,
   input  logic [DATA_W-1:0]    wb_val,
   input  logic                 wb_mispredict,
   input  logic [DATA_W-1:0]    wb_target_pc,
   output logic                 commit,
   output logic [REG_W-1:0]     commit_rd,
   output logic [DATA_W-1:0]    commit_val,
   output logic [ROB_POS_W-1:0] commit_rob_pos,
   output logic                 rollback,
   output logic [DATA_W-1:0]    rollback_pc
);

   localparam logic [ROB_POS_W:0] FULL_COUNT = (ROB_POS_W+1)'(ROB_SIZE);

   logic [ROB_SIZE-1:0]  busy;
   logic [ROB_SIZE-1:0]  ready;
   logic [ROB_SIZE-1:0]  mispred;
   logic [REG_W-1:0]     rd_mem  [ROB_SIZE];
   logic [DATA_W-1:0]    val_mem [ROB_SIZE];
   logic [DATA_W-1:0]    pc_mem  [ROB_SIZE];
   logic [ROB_POS_W-1:0] head;
   logic [ROB_POS_W-1:0] tail;
   logic [ROB_POS_W:0]   count;

   logic fire;
   logic flush;
   logic issue_acc;
   logic wb_acc;

   assign full          = (count == FULL_COUNT);
   assign issue_rob_pos = tail;

   // NOTE: every signal driven here gets a default first so no latch can be inferred.
   always_comb begin
      fire      = 1'b0;
      flush     = 1'b0;
      issue_acc = 1'b0;
      wb_acc    = 1'b0;
      fire      = busy[head] && ready[head];
      flush     = fire && mispred[head];
      // Inputs arriving while a flush is visible belong to the squashed path.
      issue_acc = issue && !full && !rollback;
      wb_acc    = wb_valid && busy[wb_rob_pos] && !rollback;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head           <= '0;
         tail           <= '0;
         count          <= '0;
         busy           <= '0;
         ready          <= '0;
         commit         <= 1'b0;
         commit_rd      <= '0;
         commit_val     <= '0;
         commit_rob_pos <= '0;
         rollback       <= 1'b0;
         rollback_pc    <= '0;
      end else if (!rdy) begin
         commit   <= 1'b0;
         rollback <= 1'b0;
      end else begin
         commit   <= fire;
         rollback <= flush;
         if (fire) begin
            commit_rd      <= rd_mem[head];
            commit_val     <= val_mem[head];
            commit_rob_pos <= head;
         end
         if (flush) begin
            rollback_pc <= pc_mem[head];
            busy        <= '0;
            ready       <= '0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
         end else begin
            if (wb_acc)
               ready[wb_rob_pos] <= 1'b1;
            if (fire) begin
               busy[head] <= 1'b0;
               head       <= head + 1'b1;
            end
            if (issue_acc) begin
               busy[tail]  <= 1'b1;
               ready[tail] <= 1'b0;
               tail        <= tail + 1'b1;
            end
            if (issue_acc && !fire)
               count <= count + 1'b1;
            else if (!issue_acc && fire)
               count <= count - 1'b1;
         end
      end
   end

   // NOTE: payload storage is not reset; busy/ready gate every use, which keeps it plain RAM.
   always_ff @(posedge clk) begin
      if (rdy) begin
         if (issue_acc) begin
            rd_mem[tail]  <= issue_rd;
            mispred[tail] <= 1'b0;
         end
         if (wb_acc) begin
            val_mem[wb_rob_pos] <= wb_val;
            pc_mem[wb_rob_pos]  <= wb_target_pc;
            mispred[wb_rob_pos] <= wb_mispredict;
         end
      end
   end

endmodule

// File: tb/tb_rob_commit_seq.sv
// Bench for rob_commit_seq: a program-order queue model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_rob_commit_seq;

   localparam int RS = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic        issue;
   logic [4:0]  issue_rd;
   logic [3:0]  issue_rob_pos;
   logic        full;
   logic        wb_valid;
   logic [3:0]  wb_rob_pos;
   logic [31:0] wb_val;
   logic        wb_mispredict;
   logic [31:0] wb_target_pc;
   logic        commit;
   logic [4:0]  commit_rd;
   logic [31:0] commit_val;
   logic [3:0]  commit_rob_pos;
   logic        rollback;
   logic [31:0] rollback_pc;

   rob_commit_seq dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .issue(issue), .issue_rd(issue_rd), .issue_rob_pos(issue_rob_pos), .full(full),
      .wb_valid(wb_valid), .wb_rob_pos(wb_rob_pos), .wb_val(wb_val),
      .wb_mispredict(wb_mispredict), .wb_target_pc(wb_target_pc),
      .commit(commit), .commit_rd(commit_rd), .commit_val(commit_val),
      .commit_rob_pos(commit_rob_pos), .rollback(rollback), .rollback_pc(rollback_pc)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: in-flight instructions in program order; head position and outputs of the last edge.
   typedef struct packed {
      logic [3:0]  pos;
      logic [4:0]  rd;
      logic        done;
      logic [31:0] val;
      logic        mis;
      logic [31:0] pc;
   } ent_t;

   ent_t        q[$];
   int          m_head;
   bit          m_commit, m_rollback;
   logic [4:0]  m_rd;
   logic [31:0] m_val, m_pc;
   logic [3:0]  m_pos;
   bit          m_fire, m_mis, m_acc, m_blocked;
   logic [3:0]  m_tail;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q.delete();
         m_head = 0; m_commit = 0; m_rollback = 0;
         m_rd = 0; m_val = 0; m_pos = 0; m_pc = 0;
      end else if (!rdy) begin
         m_commit = 0; m_rollback = 0;
      end else begin
         m_blocked = m_rollback;
         m_fire    = (q.size() > 0) && q[0].done;
         m_mis     = m_fire && q[0].mis;
         m_tail    = 4'((m_head + q.size()) % RS);
         m_acc     = issue && (q.size() < RS) && !m_blocked;
         if (m_fire) begin
            m_rd = q[0].rd; m_val = q[0].val; m_pos = q[0].pos;
         end
         if (m_mis) m_pc = q[0].pc;
         if (wb_valid && !m_blocked)
            foreach (q[i])
               if (q[i].pos == wb_rob_pos) begin
                  q[i].done = 1'b1; q[i].val = wb_val;
                  q[i].mis = wb_mispredict; q[i].pc = wb_target_pc;
               end
         if (m_mis) begin
            q.delete();
            m_head = 0;
         end else begin
            if (m_fire) begin
               void'(q.pop_front());
               m_head = (m_head + 1) % RS;
            end
            if (m_acc) q.push_back('{pos: m_tail, rd: issue_rd, done: 1'b0, val: 32'h0, mis: 1'b0, pc: 32'h0});
         end
         m_commit   = m_fire;
         m_rollback = m_mis;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         check("commit", 32'(commit), 32'(m_commit));
         check("rollback", 32'(rollback), 32'(m_rollback));
         check("full", 32'(full), 32'(q.size() == RS));
         check("issue_rob_pos", 32'(issue_rob_pos), 32'((m_head + q.size()) % RS));
         if (m_commit) begin
            check("commit_rd", 32'(commit_rd), 32'(m_rd));
            check("commit_val", commit_val, m_val);
            check("commit_rob_pos", 32'(commit_rob_pos), 32'(m_pos));
         end
         if (m_rollback) check("rollback_pc", rollback_pc, m_pc);
      end
   end

   task automatic idle_inputs();
      rdy = 1'b1; issue = 1'b0; issue_rd = '0;
      wb_valid = 1'b0; wb_rob_pos = '0; wb_val = '0; wb_mispredict = 1'b0; wb_target_pc = '0;
   endtask

   // Apply one cycle of inputs across the next edge; returns 2 time units after that edge.
   task automatic cyc(input bit iss, input logic [4:0] rd, input bit wv, input logic [3:0] wp,
                      input logic [31:0] wval, input bit wm, input logic [31:0] wpc, input bit r);
      rdy = r; issue = iss; issue_rd = rd;
      wb_valid = wv; wb_rob_pos = wp; wb_val = wval; wb_mispredict = wm; wb_target_pc = wpc;
      @(posedge clk); #2;
      idle_inputs();
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      @(posedge clk); #2;
      rst = 1'b0;
   endtask

   initial begin
      idle_inputs();
      rst = 1'b1;
      do_reset();
      check("reset_full", 32'(full), 32'h0);
      check("reset_pos", 32'(issue_rob_pos), 32'h0);
      check("reset_commit", 32'(commit), 32'h0);

      // Reset while entries are in flight.
      for (int i = 0; i < 3; i++) cyc(1, 5'(i + 1), 0, 0, 0, 0, 0, 1);
      check("t1_pos_before", 32'(issue_rob_pos), 32'h3);
      #1 rst = 1'b1;
      #1;
      check("t1_full", 32'(full), 32'h0);
      check("t1_pos", 32'(issue_rob_pos), 32'h0);
      check("t1_commit", 32'(commit), 32'h0);
      check("t1_rollback", 32'(rollback), 32'h0);
      @(posedge clk); #2 rst = 1'b0;
      cyc(1, 5'd7, 0, 0, 0, 0, 0, 1);
      check("t1_pos_after", 32'(issue_rob_pos), 32'h1);
      cyc(0, 0, 1, 4'd0, 32'h77, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 0, 1);
      check("t1_commit_hi", 32'(commit), 32'h1);
      check("t1_commit_pos", 32'(commit_rob_pos), 32'h0);
      check("t1_commit_rd", 32'(commit_rd), 32'h7);

      // Out-of-order writeback still retires in order.
      do_reset();
      cyc(1, 5'd5, 0, 0, 0, 0, 0, 1);
      cyc(1, 5'd6, 0, 0, 0, 0, 0, 1);
      cyc(0, 0, 1, 4'd1, 32'h22, 0, 0, 1);
      cyc(0, 0, 1, 4'd0, 32'h11, 0, 0, 1);
      check("t2_no_early", 32'(commit), 32'h0);
      cyc(0, 0, 0, 0, 0, 0, 0, 1);
      check("t2_c0", 32'(commit), 32'h1);
      check("t2_c0_pos", 32'(commit_rob_pos), 32'h0);
      check("t2_c0_rd", 32'(commit_rd), 32'h5);
      check("t2_c0_val", commit_val, 32'h11);
      cyc(0, 0, 0, 0, 0, 0, 0, 1);
      check("t2_c1", 32'(commit), 32'h1);
      check("t2_c1_pos", 32'(commit_rob_pos), 32'h1);
      check("t2_c1_rd", 32'(commit_rd), 32'h6);
      check("t2_c1_val", commit_val, 32'h22);
      cyc(0, 0, 0, 0, 0, 0, 0, 1);
      check("t2_idle", 32'(commit), 32'h0);

      // Full buffer rejects issue; frees after one commit.
      do_reset();
      for (int i = 0; i < 16; i++) cyc(1, 5'(i), 0, 0, 0, 0, 0, 1);
      check("t3_full", 32'(full), 32'h1);
      check("t3_pos", 32'(issue_rob_pos), 32'h0);
      cyc(1, 5'd9, 0, 0, 0, 0, 0, 1);
      check("t3_full_17", 32'(full), 32'h1);
      check("t3_pos_17", 32'(issue_rob_pos), 32'h0);
      cyc(0, 0, 1, 4'd0, 32'h5a, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 0, 1);
      check("t3_commit", 32'(commit), 32'h1);
      check("t3_commit_pos", 32'(commit_rob_pos), 32'h0);
      check("t3_not_full", 32'(full), 32'h0);

      // Pointer wrap across 20 rounds.
      do_reset();
      for (int r = 0; r < 20; r++) begin
         cyc(1, 5'(r + 3), 0, 0, 0, 0, 0, 1);
         cyc(0, 0, 1, 4'(r % 16), 32'(r), 0, 0, 1);
         cyc(0, 0, 0, 0, 0, 0, 0, 1);
         check("t4_commit", 32'(commit), 32'h1);
         check("t4_pos", 32'(commit_rob_pos), 32'(r % 16));
         check("t4_rd", 32'(commit_rd), 32'((r + 3) % 32));
      end

      // Mispredict at head flushes; stale inputs during rollback ignored.
      do_reset();
      for (int i = 0; i < 4; i++) cyc(1, 5'(i + 1), 0, 0, 0, 0, 0, 1);
      cyc(0, 0, 1, 4'd0, 32'hA, 0, 0, 1);
      cyc(0, 0, 1, 4'd1, 32'hB, 1, 32'h100, 1);
      check("t5_c0", 32'(commit), 32'h1);
      check("t5_c0_pos", 32'(commit_rob_pos), 32'h0);
      check("t5_c0_rb", 32'(rollback), 32'h0);
      cyc(0, 0, 0, 0, 0, 0, 0, 1);
      check("t5_c1", 32'(commit), 32'h1);
      check("t5_c1_pos", 32'(commit_rob_pos), 32'h1);
      check("t5_c1_rd", 32'(commit_rd), 32'h2);
      check("t5_rb", 32'(rollback), 32'h1);
      check("t5_rb_pc", rollback_pc, 32'h100);
      check("t5_pos_zero", 32'(issue_rob_pos), 32'h0);
      cyc(1, 5'd9, 1, 4'd2, 32'hC, 0, 0, 1);
      check("t5_rb_clear", 32'(rollback), 32'h0);
      check("t5_issue_ign", 32'(issue_rob_pos), 32'h0);
      cyc(0, 0, 0, 0, 0, 0, 0, 1);
      check("t5_no_commit", 32'(commit), 32'h0);

      // rdy low freezes a ready head.
      do_reset();
      cyc(1, 5'd3, 0, 0, 0, 0, 0, 1);
      cyc(0, 0, 1, 4'd0, 32'h33, 0, 0, 1);
      for (int i = 0; i < 3; i++) begin
         cyc(1, 5'd4, 0, 0, 0, 0, 0, 0);
         check("t6_frozen", 32'(commit), 32'h0);
         check("t6_pos", 32'(issue_rob_pos), 32'h1);
      end
      cyc(0, 0, 0, 0, 0, 0, 0, 1);
      check("t6_commit", 32'(commit), 32'h1);
      check("t6_val", commit_val, 32'h33);

      // Randomized traffic checked by the model every cycle.
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         bit          r_iss, r_wv, r_wm, r_rdy;
         logic [3:0]  r_wp;
         r_rdy = ($urandom_range(0, 9) != 0);
         r_iss = ($urandom_range(0, 9) < 6);
         r_wv  = ($urandom_range(0, 1) == 1);
         r_wm  = ($urandom_range(0, 15) == 0);
         if (q.size() > 0 && $urandom_range(0, 4) != 0)
            r_wp = q[$urandom_range(0, q.size() - 1)].pos;
         else
            r_wp = 4'($urandom_range(0, 15));
         cyc(r_iss, 5'($urandom), r_wv, r_wp, $urandom, r_wm, $urandom, r_rdy);
      end
      repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
